// File: rtl/lfsr_seed_loader.sv
// rtl/lfsr_seed_loader.sv - LFSR-driven initial board loader; optional LFSR_RESEED_EN reseeds the LFSR on rst
module lfsr_seed_loader #(
  parameter int          GRID_W = 64,
  parameter int          GRID_H = 64,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      rst,
  input  logic                                      en,
  output logic                                      row_we,
  output logic [((GRID_H > 1) ? $clog2(GRID_H) : 1)-1:0] row_addr,
  output logic [GRID_W-1:0]                         row_data,
  output logic                                      busy,
  output logic                                      load_done
);

  localparam int AW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int BW = $clog2(GRID_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(GRID_W - 1);
  localparam logic [AW-1:0] ROW_LAST = AW'(GRID_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  // Only the GRID_W-1 most recent bits are kept; the row completes with the current LFSR bit.
  logic [GRID_W-2:0]   row_buf_q, row_buf_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]       row_cnt_q, row_cnt_d;
  logic                row_we_q, row_we_d;
  logic [AW-1:0]       row_addr_q, row_addr_d;
  logic [GRID_W-1:0]   row_data_q, row_data_d;
  logic                busy_q, busy_d;
  logic                load_done_q, load_done_d;

  logic [15:0]         lfsr_next;
  logic [GRID_W-1:0]   row_next;

  // Next-state logic: rst clears, en aborts/releases, FILL shifts one LFSR bit per cycle.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    row_buf_d   = row_buf_q;
    bit_cnt_d   = bit_cnt_q;
    row_cnt_d   = row_cnt_q;
    row_we_d    = 1'b0;
    row_addr_d  = row_addr_q;
    row_data_d  = row_data_q;
    busy_d      = 1'b0;
    load_done_d = 1'b0;

    lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    row_next  = {row_buf_q, lfsr_q[15]};

    if (rst) begin
      state_d   = IDLE;
      row_buf_d = '0;
      bit_cnt_d = '0;
      row_cnt_d = '0;
`ifdef LFSR_RESEED_EN
      lfsr_d    = SEED;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!en) begin
            state_d   = FILL;
            busy_d    = 1'b1;
            row_buf_d = '0;
            bit_cnt_d = '0;
            row_cnt_d = '0;
          end
        end
        FILL: begin
          if (en) begin
            // Abort: the partially collected row is dropped without a write.
            state_d   = IDLE;
            row_buf_d = '0;
            bit_cnt_d = '0;
            row_cnt_d = '0;
          end else begin
            lfsr_d    = lfsr_next;
            row_buf_d = row_next[GRID_W-2:0];
            busy_d    = 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              row_we_d   = 1'b1;
              row_data_d = row_next;
              row_addr_d = row_cnt_q;
              bit_cnt_d  = '0;
              if (row_cnt_q == ROW_LAST) begin
                state_d   = DONE;
                busy_d    = 1'b0;
                row_cnt_d = '0;
              end else begin
                row_cnt_d = row_cnt_q + 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (en) begin
            state_d = IDLE;
          end else begin
            // Hold off one cycle past the final row strobe so the last write lands first.
            load_done_d = !row_we_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; async reset restores the seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      row_buf_q   <= '0;
      bit_cnt_q   <= '0;
      row_cnt_q   <= '0;
      row_we_q    <= 1'b0;
      row_addr_q  <= '0;
      row_data_q  <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      row_buf_q   <= row_buf_d;
      bit_cnt_q   <= bit_cnt_d;
      row_cnt_q   <= row_cnt_d;
      row_we_q    <= row_we_d;
      row_addr_q  <= row_addr_d;
      row_data_q  <= row_data_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
    end
  end

  assign row_we    = row_we_q;
  assign row_addr  = row_addr_q;
  assign row_data  = row_data_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;

endmodule

// File: tb/tb_lfsr_seed_loader.sv
// tb/tb_lfsr_seed_loader.sv - directed vector bench for lfsr_seed_loader (GRID_W=4, GRID_H=3)
module tb_lfsr_seed_loader;

  logic       clk;
  logic       reset;
  logic       rst;
  logic       en;
  logic       row_we;
  logic [1:0] row_addr;
  logic [3:0] row_data;
  logic       busy;
  logic       load_done;

  int vectors;
  int miscompares;

  typedef struct {
    logic       r;
    logic       e;
    logic       we;
    logic [1:0] addr;
    logic [3:0] data;
    logic       b;
    logic       ld;
  } vec_t;

  vec_t tbl[$];

  lfsr_seed_loader #(
    .GRID_W(4),
    .GRID_H(3),
    .SEED  (16'hACE1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rst      (rst),
    .en       (en),
    .row_we   (row_we),
    .row_addr (row_addr),
    .row_data (row_data),
    .busy     (busy),
    .load_done(load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic areset();
    en    = 1'b1;
    rst   = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic add(input int n, input logic r, input logic e, input logic w,
                     input logic [1:0] a, input logic [3:0] d, input logic b, input logic l);
    vec_t v;
    v = '{r: r, e: e, we: w, addr: a, data: d, b: b, ld: l};
    repeat (n) tbl.push_back(v);
  endtask

  initial begin
    int we_cnt;
    int busy_cnt;
    int ld_cnt;
    logic [3:0] exp_row0;

    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    rst   = 1'b0;
    en    = 1'b1;
    #3;
    chk("reset_row_we",    32'(row_we),    32'd0);
    chk("reset_row_addr",  32'(row_addr),  32'd0);
    chk("reset_row_data",  32'(row_data),  32'd0);
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_load_done", 32'(load_done), 32'd0);
    #9;
    reset = 1'b0;

    // First load (seed ACE1 -> rows A, C, E), release with en, second load (rows 1, 8, A).
    add(1,  0, 0, 0, 2'd0, 4'h0, 1, 0);
    add(3,  0, 0, 0, 2'd0, 4'h0, 1, 0);
    add(1,  0, 0, 1, 2'd0, 4'hA, 1, 0);
    add(3,  0, 0, 0, 2'd0, 4'h0, 1, 0);
    add(1,  0, 0, 1, 2'd1, 4'hC, 1, 0);
    add(3,  0, 0, 0, 2'd1, 4'h0, 1, 0);
    add(1,  0, 0, 1, 2'd2, 4'hE, 0, 0);
    add(1,  0, 0, 0, 2'd2, 4'h0, 0, 0);
    add(2,  0, 0, 0, 2'd2, 4'h0, 0, 1);
    add(1,  0, 1, 0, 2'd2, 4'h0, 0, 0);
    add(1,  0, 0, 0, 2'd2, 4'h0, 1, 0);
    add(3,  0, 0, 0, 2'd2, 4'h0, 1, 0);
    add(1,  0, 0, 1, 2'd0, 4'h1, 1, 0);
    add(3,  0, 0, 0, 2'd0, 4'h0, 1, 0);
    add(1,  0, 0, 1, 2'd1, 4'h8, 1, 0);
    add(3,  0, 0, 0, 2'd1, 4'h0, 1, 0);
    add(1,  0, 0, 1, 2'd2, 4'hA, 0, 0);
    add(1,  0, 0, 0, 2'd2, 4'h0, 0, 0);
    add(1,  0, 0, 0, 2'd2, 4'h0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].e);
      chk($sformatf("tbl%0d_row_we", i),    32'(row_we),    32'(tbl[i].we));
      chk($sformatf("tbl%0d_row_addr", i),  32'(row_addr),  32'(tbl[i].addr));
      chk($sformatf("tbl%0d_busy", i),      32'(busy),      32'(tbl[i].b));
      chk($sformatf("tbl%0d_load_done", i), 32'(load_done), 32'(tbl[i].ld));
      if (tbl[i].we)
        chk($sformatf("tbl%0d_row_data", i), 32'(row_data), 32'(tbl[i].data));
    end

    // rst in DONE, then a new fill: reseed gives A, otherwise LFSR bits 24..27 = 8.
    cyc(1, 0);
    chk("rst_done_busy",      32'(busy),      32'd0);
    chk("rst_done_row_we",    32'(row_we),    32'd0);
    chk("rst_done_load_done", 32'(load_done), 32'd0);
`ifdef LFSR_RESEED_EN
    exp_row0 = 4'hA;
`else
    exp_row0 = 4'h8;
`endif
    cyc(0, 0);
    repeat (4) cyc(0, 0);
    chk("after_rst_done_row_we",   32'(row_we),   32'd1);
    chk("after_rst_done_row_addr", 32'(row_addr), 32'd0);
    chk("after_rst_done_row0",     32'(row_data), 32'(exp_row0));

    // rst in FILL (mid row 1).
    cyc(1, 0);
    chk("rst_fill_busy",      32'(busy),      32'd0);
    chk("rst_fill_row_we",    32'(row_we),    32'd0);
    chk("rst_fill_load_done", 32'(load_done), 32'd0);

    // rst held with en=0 in IDLE: no start.
    we_cnt = 0; busy_cnt = 0; ld_cnt = 0;
    repeat (10) begin
      cyc(1, 0);
      we_cnt   += int'(row_we);
      busy_cnt += int'(busy);
      ld_cnt   += int'(load_done);
    end
    chk("rst_idle_row_we_count",    32'(we_cnt),   32'd0);
    chk("rst_idle_busy_count",      32'(busy_cnt), 32'd0);
    chk("rst_idle_load_done_count", 32'(ld_cnt),   32'd0);
    cyc(0, 0);
    chk("rst_release_busy", 32'(busy), 32'd1);
    repeat (4) cyc(0, 0);
    chk("after_rst_fill_row_we", 32'(row_we), 32'd1);
`ifdef LFSR_RESEED_EN
    chk("after_rst_fill_row0_reseed", 32'(row_data), 32'hA);
`else
    chk("after_rst_fill_row0_differs", 32'(row_data != 4'hA), 32'd1);
`endif

    // Abort with en=1 at FILL cycle 6: only row 0 is written.
    areset();
    we_cnt = 0; ld_cnt = 0;
    cyc(0, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0);
      we_cnt += int'(row_we);
    end
    cyc(0, 1);
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_row_we", 32'(row_we), 32'd0);
    ld_cnt += int'(load_done);
    repeat (8) begin
      cyc(0, 1);
      we_cnt += int'(row_we);
      ld_cnt += int'(load_done);
    end
    chk("abort_row_we_count",    32'(we_cnt),   32'd1);
    chk("abort_load_done_count", 32'(ld_cnt),   32'd0);
    chk("abort_row_addr",        32'(row_addr), 32'd0);

    // Async reset mid-FILL: outputs clear at once and the seed is restored.
    areset();
    repeat (5) cyc(0, 0);
    chk("pre_areset_row_we", 32'(row_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("areset_row_we",    32'(row_we),    32'd0);
    chk("areset_busy",      32'(busy),      32'd0);
    chk("areset_load_done", 32'(load_done), 32'd0);
    chk("areset_row_data",  32'(row_data),  32'd0);
    chk("areset_row_addr",  32'(row_addr),  32'd0);
    #1;
    reset = 1'b0;
    repeat (5) cyc(0, 0);
    chk("post_areset_row_we", 32'(row_we),   32'd1);
    chk("post_areset_row0",   32'(row_data), 32'hA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_seed_loader.md
Name: lfsr_seed_loader

Overview:
- Downstream of the run/load control FSM. It consumes that FSM's en and rst outputs and produces its lfsr_load input (here load_done).
- While the FSM holds the load phase (rst=0, en=0), the block generates a pseudo-random initial board with a 16-bit LFSR. It writes the board row by row into the cell-grid storage, then raises load_done so the FSM can start the run phase.

Parameters:
- GRID_W, 64, cells per row (bits of row_data); legal range 2..64
- GRID_H, 64, number of rows; legal range 1..256
- SEED, 16'hACE1, LFSR value after async reset; must be nonzero

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset; clock clk
- rst  in  1  synchronous clear from the control FSM; highest priority after reset
- en  in  1  run enable from the control FSM; load is requested when en=0 and rst=0
- row_we  out  1  one-cycle row write strobe
- row_addr  out  $clog2(GRID_H) (min 1)  row index being written
- row_data  out  GRID_W  row contents; valid only while row_we=1
- busy  out  1  high while in FILL
- load_done  out  1  level, high in DONE; drives the FSM's lfsr_load input

Behaviour:
- Async reset:
  - state=IDLE, lfsr=SEED.
  - row_buf, bit_cnt, row_cnt = 0.
  - row_we=0, row_addr=0, row_data=0, busy=0, load_done=0.
- LFSR:
  - Fibonacci, x^16+x^15+x^13+x^4+1.
  - fb = l[15]^l[14]^l[12]^l[3]; next = {l[14:0], fb}.
  - Output bit is l[15] of the current state.
  - Steps only in FILL, one step per cycle; holds in IDLE and DONE.
- States: IDLE, FILL, DONE. All outputs are registered.
- IDLE:
  - If rst=0 and en=0, go to FILL next cycle.
  - bit_cnt and row_cnt are cleared on entry to FILL.
- FILL, each cycle:
  - row_buf <= {row_buf[GRID_W-2:0], lfsr[15]}; lfsr steps.
  - The first bit generated for a row ends in row_data[GRID_W-1] (MSB).
  - When bit_cnt = GRID_W-1, the next cycle has row_we=1, row_data=the completed row, row_addr=row_cnt.
  - On that same completion, bit_cnt wraps to 0 and row_cnt increments.
  - Bit capture continues every cycle without gaps; the write strobe overlaps the next row's first bit.
  - After the last row (row_cnt = GRID_H-1) completes, go to DONE. That row's row_we cycle coincides with the first DONE cycle.
  - busy=1 throughout FILL.
- DONE:
  - load_done=1 from the cycle after the last row_we.
  - Stay in DONE while en=0.
  - On en=1, go to IDLE; load_done=0 the next cycle. This lets the FSM observe lfsr_load low and accept a new start.
- Timing: with en=0 sampled at edge 0, FILL runs edges 1..GRID_W*GRID_H, and load_done first reads 1 after edge GRID_W*GRID_H+2.
- Priority, highest first: reset > rst > en.
  - rst=1 in any state: next state IDLE; row_we, busy, load_done drop next cycle; counters cleared; lfsr is not reseeded (but see Optional Feature).
  - en=1 during FILL (abort): go to IDLE next cycle. Rows already written stay written; a partially collected row is discarded (no row_we); load_done stays 0.
  - en=0 in IDLE with rst=1: no start.
- Re-entering FILL after a completed load continues from the LFSR's current state, so each reload gives a different board.
- row_addr holds its last value when row_we=0.

Optional Feature:
- Macro: LFSR_RESEED_EN
- Defined: rst=1 also loads lfsr <= SEED, so every reload after an FSM reset produces the identical board (debug/demo determinism).
- Undefined: only async reset loads SEED; rst leaves lfsr untouched.

Test Plan:
- GRID_W=4, GRID_H=3, SEED=16'hACE1; reset, then rst=0, en=0 -> first row_we with row_addr=0, row_data=4'hA. Rows 1 and 2 match the LFSR model. row_we is high exactly 3 cycles, spaced 4 apart. load_done rises 14 cycles after en was sampled 0; busy is high for 12 cycles.
- From DONE, en=1 for one cycle -> state IDLE, load_done=0 next cycle. Then en=0 -> second fill's row 0 equals LFSR model bits 12..15, not 4'hA.
- en=1 at FILL cycle 6 (mid row 1) -> exactly one row_we (row 0), row 1 never written, load_done stays 0, busy=0 next cycle.
- rst=1 in FILL, DONE and IDLE -> IDLE next cycle, all strobes 0. With LFSR_RESEED_EN defined, the next fill's row 0 = 4'hA; without it, row 0 differs.
- rst=1 and en=0 held together -> no FILL, busy=0, row_we never asserts. Asserting async reset mid-FILL -> all outputs 0 immediately, lfsr=SEED.
